// File: rtl/alu_opcodes_pkg.sv
// Opcode set of the ALU under test plus the constants shared by the BIST controller:
// feedback polynomial, opcode table in package order, FSM state codes and the Galois step.
package alu_opcodes_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_AND  = 5'd3,
        ALU_OR   = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SLL  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_SRA  = 5'd8,
        ALU_SLT  = 5'd9,
        ALU_SLTU = 5'd10
    } alu_op_e;

    localparam int unsigned ALU_BIST_NUM_OPS = 10;
    localparam int unsigned ALU_BIST_OP_W    = $clog2(ALU_BIST_NUM_OPS);
    localparam logic [31:0] ALU_BIST_POLY    = 32'h8020_0003;

    localparam logic [4:0] ALU_BIST_OPS [ALU_BIST_NUM_OPS] = '{
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    };

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Left-shifting Galois step; shared by the operand LFSR and the MISR.
    function automatic logic [31:0] alu_bist_galois(input logic [31:0] v);
        return {v[30:0], 1'b0} ^ (v[31] ? ALU_BIST_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/alu_bist_lfsr.sv
// 32-bit Galois operand generator: load reloads the seed, step advances one position.
module alu_bist_lfsr
    import alu_opcodes_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    output logic [31:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
        end else if (load) begin
            state <= SEED;
        end else if (step) begin
            state <= alu_bist_galois(state);
        end
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// Built-in self-test controller for a 32-bit ALU: sweeps every opcode with LFSR operands,
// compacts results in a MISR and compares against a golden signature. Macro ALU_BIST_FLAG_EN
// also folds the ALU comparison flag into the signature.
module alu_bist_ctrl
    import alu_opcodes_pkg::*;
#(
    parameter int unsigned VECTORS_PER_OP = 16,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_2024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] expected_sig_i,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [4:0]  alu_op_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_flag_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [31:0] signature_o,
    output logic [1:0]  state_o
);

    localparam int unsigned VEC_W = (VECTORS_PER_OP > 1) ? $clog2(VECTORS_PER_OP) : 1;

    logic [1:0]               state;
    logic [VEC_W-1:0]         vec_cnt;
    logic [ALU_BIST_OP_W-1:0] op_idx;
    logic [31:0]              misr;
    logic [31:0]              misr_next;
    logic [31:0]              lfsr;
    logic                     running;
    logic                     start_run;
    logic                     vec_last;
    logic                     run_last;

    assign running   = (state == S_RUN);
    assign start_run = start_i && ((state == S_IDLE) || (state == S_DONE));
    assign vec_last  = (vec_cnt == VEC_W'(VECTORS_PER_OP - 1));
    assign run_last  = vec_last && (op_idx == ALU_BIST_OP_W'(ALU_BIST_NUM_OPS - 1));

    alu_bist_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .load  (start_run),
        .step  (running),
        .state (lfsr)
    );

`ifdef ALU_BIST_FLAG_EN
    assign misr_next = alu_bist_galois(misr) ^ alu_result_i ^ {31'b0, alu_flag_i};
`else
    logic unused_flag;
    assign unused_flag = alu_flag_i;
    assign misr_next   = alu_bist_galois(misr) ^ alu_result_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_IDLE;
            vec_cnt <= '0;
            op_idx  <= '0;
            misr    <= '0;
            pass_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state   <= S_RUN;
                        vec_cnt <= '0;
                        op_idx  <= '0;
                        misr    <= '0;
                        pass_o  <= 1'b0;
                        done_o  <= 1'b0;
                    end
                end
                S_RUN: begin
                    misr    <= misr_next;
                    vec_cnt <= vec_last ? '0 : vec_cnt + 1'b1;
                    // Wrap the op index on the final vector so it never leaves the table.
                    if (run_last) begin
                        op_idx <= '0;
                        state  <= S_CHECK;
                    end else if (vec_last) begin
                        op_idx <= op_idx + 1'b1;
                    end
                end
                S_CHECK: begin
                    pass_o <= (misr == expected_sig_i);
                    done_o <= 1'b1;
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operands come straight from registers and are forced to zero outside RUN.
    assign alu_a_o     = running ? lfsr : 32'h0;
    assign alu_b_o     = running ? {lfsr[15:0], lfsr[31:16]} : 32'h0;
    assign alu_op_o    = running ? ALU_BIST_OPS[op_idx] : 5'd0;
    assign busy_o      = running || (state == S_CHECK);
    assign signature_o = misr;
    assign state_o     = state;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: two instances (1 and 3 vectors per opcode), a behavioural ALU,
// a phase-level reference model checked every cycle, and directed scenarios with literal pins.
`timescale 1ns/1ps
module tb_alu_bist_ctrl;
    import alu_opcodes_pkg::*;

    localparam int NI   = 2;
    localparam int VPO0 = 1;
    localparam int VPO1 = 3;
    localparam logic [31:0] SEED = 32'hACE1_2024;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_CHECK = 2;
    localparam int P_DONE  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic fault = 1'b0;
    logic cmp_en = 1'b0;

    logic [31:0] exp_sig [NI];
    logic [31:0] a       [NI];
    logic [31:0] b       [NI];
    logic [4:0]  op      [NI];
    logic [31:0] res     [NI];
    logic        flag    [NI];
    logic        busy    [NI];
    logic        done    [NI];
    logic        pass    [NI];
    logic [31:0] sig     [NI];
    logic [1:0]  st      [NI];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // ---------------- behavioural ALU and specification-level helpers ----------------
    function automatic logic [31:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                           input logic [4:0] o);
        case (o)
            ALU_ADD:  return x + y;
            ALU_SUB:  return x - y;
            ALU_AND:  return x & y;
            ALU_OR:   return x | y;
            ALU_XOR:  return x ^ y;
            ALU_SLL:  return x << y[4:0];
            ALU_SRL:  return x >> y[4:0];
            ALU_SRA:  return $unsigned($signed(x) >>> y[4:0]);
            ALU_SLT:  return {31'b0, $signed(x) < $signed(y)};
            ALU_SLTU: return {31'b0, x < y};
            default:  return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] step32(input logic [31:0] v);
        return (v << 1) ^ (v[31] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] swap16(input logic [31:0] v);
        return {v[15:0], v[31:16]};
    endfunction

    function automatic int vpo_of(input int i);
        return (i == 0) ? VPO0 : VPO1;
    endfunction

    function automatic logic [4:0] op_at(input int k, input int vpo);
        return ALU_BIST_OPS[ALU_BIST_OP_W'(k / vpo)];
    endfunction

    function automatic logic [31:0] vec_result(input logic [31:0] l, input int k,
                                               input int vpo, input logic flt);
        logic [31:0] r;
        r = alu_fn(l, swap16(l), op_at(k, vpo));
        if (flt) r[0] = 1'b0;
`ifdef ALU_BIST_FLAG_EN
        r[0] = r[0] ^ (l < swap16(l));
`endif
        return r;
    endfunction

    // Whole-run signature computed directly as a loop over all vectors.
    function automatic logic [31:0] sig_model(input int vpo, input logic flt);
        logic [31:0] l;
        logic [31:0] m;
        l = SEED;
        m = 32'h0;
        for (int k = 0; k < ALU_BIST_NUM_OPS * vpo; k++) begin
            m = step32(m) ^ vec_result(l, k, vpo, flt);
            l = step32(l);
        end
        return m;
    endfunction

    // ---------------- DUTs ----------------
    for (genvar g = 0; g < NI; g++) begin : g_dut
        alu_bist_ctrl #(
            .VECTORS_PER_OP ((g == 0) ? VPO0 : VPO1),
            .LFSR_SEED      (SEED)
        ) dut (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .start_i        (start),
            .expected_sig_i (exp_sig[g]),
            .alu_a_o        (a[g]),
            .alu_b_o        (b[g]),
            .alu_op_o       (op[g]),
            .alu_result_i   (res[g]),
            .alu_flag_i     (flag[g]),
            .busy_o         (busy[g]),
            .done_o         (done[g]),
            .pass_o         (pass[g]),
            .signature_o    (sig[g]),
            .state_o        (st[g])
        );
        assign res[g]  = alu_fn(a[g], b[g], op[g]) & ~{31'b0, fault};
        assign flag[g] = (a[g] < b[g]);
    end

    // ---------------- reference model ----------------
    int          m_phase [NI];
    int          m_k     [NI];
    logic [31:0] m_lfsr  [NI];
    logic [31:0] m_misr  [NI];
    logic        m_pass  [NI];
    logic        m_done  [NI];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_phase[i] <= P_IDLE;
                m_k[i]     <= 0;
                m_lfsr[i]  <= 32'h0;
                m_misr[i]  <= 32'h0;
                m_pass[i]  <= 1'b0;
                m_done[i]  <= 1'b0;
            end else if (m_phase[i] == P_RUN) begin
                m_misr[i] <= step32(m_misr[i]) ^ vec_result(m_lfsr[i], m_k[i], vpo_of(i), fault);
                m_lfsr[i] <= step32(m_lfsr[i]);
                m_k[i]    <= m_k[i] + 1;
                if (m_k[i] == ALU_BIST_NUM_OPS * vpo_of(i) - 1) m_phase[i] <= P_CHECK;
            end else if (m_phase[i] == P_CHECK) begin
                m_pass[i]  <= (m_misr[i] == exp_sig[i]);
                m_done[i]  <= 1'b1;
                m_phase[i] <= P_DONE;
            end else if (start) begin
                m_phase[i] <= P_RUN;
                m_k[i]     <= 0;
                m_lfsr[i]  <= SEED;
                m_misr[i]  <= 32'h0;
                m_pass[i]  <= 1'b0;
                m_done[i]  <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %h want %h", name, inst, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < NI; i++) begin
                check("a", i, a[i], (m_phase[i] == P_RUN) ? m_lfsr[i] : 32'h0);
                check("b", i, b[i], (m_phase[i] == P_RUN) ? swap16(m_lfsr[i]) : 32'h0);
                check("op", i, {27'b0, op[i]},
                      (m_phase[i] == P_RUN) ? {27'b0, op_at(m_k[i], vpo_of(i))} : 32'h0);
                check("busy", i, {31'b0, busy[i]},
                      {31'b0, (m_phase[i] == P_RUN) || (m_phase[i] == P_CHECK)});
                check("done", i, {31'b0, done[i]}, {31'b0, m_done[i]});
                check("pass", i, {31'b0, pass[i]}, {31'b0, m_pass[i]});
                check("sig", i, sig[i], m_misr[i]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(input int i, input string tag);
        int n;
        n = 0;
        while (done[i] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, i, {31'b0, done[i]}, 32'd1);
    endtask

    task automatic busy_len(input int i, output int len);
        len = 0;
        while (busy[i] === 1'b1 && len < 400) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int i = 0; i < NI; i++) begin
            check({tag, "_busy"}, i, {31'b0, busy[i]}, 32'd0);
            check({tag, "_done"}, i, {31'b0, done[i]}, 32'd0);
            check({tag, "_pass"}, i, {31'b0, pass[i]}, 32'd0);
            check({tag, "_sig"}, i, sig[i], 32'd0);
            check({tag, "_a"}, i, a[i], 32'd0);
            check({tag, "_op"}, i, {27'b0, op[i]}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [31:0] ok_sig [NI];
        int l0, l1;

        ok_sig[0] = sig_model(VPO0, 1'b0);
        ok_sig[1] = sig_model(VPO1, 1'b0);
        exp_sig[0] = ok_sig[0];
        exp_sig[1] = ok_sig[1];

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);

        // First run: operand pins, busy length, pass.
        pulse_start();
        for (int i = 0; i < NI; i++) begin
            check("first_a", i, a[i], 32'hACE1_2024);
            check("first_b", i, b[i], 32'h2024_ACE1);
            check("first_op", i, {27'b0, op[i]}, 32'd1);
        end
        @(negedge clk);
        check("second_a", 0, a[0], 32'hD9E2_404B);
        check("second_sig", 0, sig[0], 32'hCD05_CD05);
        busy_len(0, l0);
        check("busy_len", 0, l0 + 1, ALU_BIST_NUM_OPS * VPO0 + 1);
        check("done_after_busy", 0, {31'b0, done[0]}, 32'd1);
        check("pass_good", 0, {31'b0, pass[0]}, 32'd1);
        wait_done(1, "done_wait");
        check("pass_good", 1, {31'b0, pass[1]}, 32'd1);
        check("sig_final", 1, sig[1], ok_sig[1]);
        repeat (3) @(negedge clk);
        check("sig_hold", 0, sig[0], ok_sig[0]);

        // Restart from DONE with a wrong golden value.
        exp_sig[0] = ok_sig[0] ^ 32'h1;
        exp_sig[1] = ok_sig[1] ^ 32'h1;
        pulse_start();
        for (int i = 0; i < NI; i++) begin
            check("restart_sig_clear", i, sig[i], 32'h0);
            check("restart_done_clear", i, {31'b0, done[i]}, 32'd0);
        end
        for (int i = 0; i < NI; i++) begin
            wait_done(i, "done_wait");
            check("pass_bad_golden", i, {31'b0, pass[i]}, 32'd0);
        end

        // Stuck-at-0 on result bit 0.
        exp_sig[0] = ok_sig[0];
        exp_sig[1] = ok_sig[1];
        fault = 1'b1;
        pulse_start();
        for (int i = 0; i < NI; i++) wait_done(i, "done_wait");
        fault = 1'b0;
        for (int i = 0; i < NI; i++) check("pass_fault", i, {31'b0, pass[i]}, 32'd0);

        // Abort at vector 5, then a clean rerun.
        pulse_start();
        repeat (5) @(negedge clk);
        check("abort_busy_before", 1, {31'b0, busy[1]}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("abort");
        for (int i = 0; i < NI; i++) check("abort_state", i, {30'b0, st[i]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < NI; i++) begin
            wait_done(i, "done_wait");
            check("rerun_sig", i, sig[i], ok_sig[i]);
            check("rerun_pass", i, {31'b0, pass[i]}, 32'd1);
        end

        // start held high through RUN.
        start = 1'b1;
        @(negedge clk);
        fork
            busy_len(0, l0);
            busy_len(1, l1);
        join
        start = 1'b0;
        check("held_busy_len", 0, l0, ALU_BIST_NUM_OPS * VPO0 + 1);
        check("held_busy_len", 1, l1, ALU_BIST_NUM_OPS * VPO1 + 1);
        for (int i = 0; i < NI; i++) begin
            wait_done(i, "done_wait");
            check("held_pass", i, {31'b0, pass[i]}, 32'd1);
        end
        repeat (2) @(negedge clk);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_bist_ctrl.md
ALU_BIST_CTRL -- requirements
Module: alu_bist_ctrl

Interface
REQ-001 SHALL have parameter VECTORS_PER_OP, default 16, number of operand vectors applied per opcode (1..256).
REQ-002 SHALL have parameter LFSR_SEED, default 32'hACE1_2024, nonzero operand generator seed.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start_i  input  1  begin a self-test run; sampled only in IDLE and DONE.
REQ-006 SHALL have port expected_sig_i  input  32  golden signature; sampled in CHECK.
REQ-007 SHALL have port alu_a_o  output  32  operand A to the ALU under test.
REQ-008 SHALL have port alu_b_o  output  32  operand B to the ALU under test.
REQ-009 SHALL have port alu_op_o  output  5  ALU opcode to the ALU under test.
REQ-010 SHALL have port alu_result_i  input  32  ALU result, combinational response to alu_a_o/alu_b_o/alu_op_o.
REQ-011 SHALL have port alu_flag_i  input  1  ALU comparison flag.
REQ-012 SHALL have port busy_o  output  1  high in RUN and CHECK.
REQ-013 SHALL have port done_o  output  1  high in DONE (level, not a pulse).
REQ-014 SHALL have port pass_o  output  1  signature match; valid while done_o=1.
REQ-015 SHALL have port signature_o  output  32  current MISR contents.

Function
REQ-016 SHALL implement FSM IDLE->RUN->CHECK->DONE; start_i=1 in IDLE or DONE -> RUN next edge; start_i ignored in RUN and CHECK.
REQ-017 SHALL, on entering RUN, load LFSR=LFSR_SEED, MISR=0, op index=0, vector count=0, pass_o=0, done_o=0.
REQ-018 SHALL drive, in each RUN cycle, registered alu_a_o=LFSR state, alu_b_o={LFSR[15:0],LFSR[31:16]}, alu_op_o=ALU_BIST_OPS[op index].
REQ-019 SHALL, at each RUN edge, update MISR=shift-left-1 of MISR XOR (ALU_BIST_POLY if old MISR[31]=1) XOR alu_result_i, and step LFSR as 32-bit Galois using ALU_BIST_POLY.
REQ-020 SHALL increment vector count per RUN cycle; on reaching VECTORS_PER_OP-1, wrap count to 0 and increment op index.
REQ-021 SHALL move RUN->CHECK on the edge absorbing the last vector; RUN length exactly ALU_BIST_NUM_OPS*VECTORS_PER_OP cycles.
REQ-022 SHALL, in CHECK (one cycle), register pass_o=(MISR==expected_sig_i), set done_o=1, go to DONE.
REQ-023 SHALL drive alu_a_o=0, alu_b_o=0, alu_op_o=0 in IDLE, CHECK and DONE.
REQ-024 SHALL hold MISR, pass_o and done_o in DONE until the next start_i.

Reset
REQ-025 SHALL, on rst_ni=0 at any time (including mid-RUN), immediately force IDLE and all outputs and internal registers to 0; LFSR reloads on next start.

Configuration
REQ-026 SHALL, with ALU_BIST_FLAG_EN defined, additionally XOR alu_flag_i into MISR bit 0 each RUN edge; without it, alu_flag_i is unused and has no effect.

Structure
REQ-027 SHALL place ALU_BIST_POLY (32'h8020_0003), ALU_BIST_NUM_OPS and opcode table ALU_BIST_OPS (all ALU opcodes, package order) in alu_opcodes_pkg.
REQ-028 SHALL implement the operand generator as sub-module alu_bist_lfsr (load, step, 32-bit state); MISR stays inline.

Verification
REQ-029 SHALL verify reset: rst_ni=0 -> busy_o=0, done_o=0, pass_o=0, signature_o=0, alu_a_o=0, alu_op_o=0.
REQ-030 SHALL verify timing: VECTORS_PER_OP=1, start pulse -> first RUN cycle alu_a_o=32'hACE1_2024, alu_b_o=32'h2024_ACE1, alu_op_o=ALU_BIST_OPS[0]; busy_o high ALU_BIST_NUM_OPS+1 cycles, then done_o=1.
REQ-031 SHALL verify pass/fail: with behavioural ALU attached, expected_sig_i=bench-model signature -> pass_o=1; expected_sig_i=model^32'h1 -> pass_o=0.
REQ-032 SHALL verify fault detection: alu_result_i[0] forced 0 during run -> pass_o=0 against fault-free signature.
REQ-033 SHALL verify abort/determinism: rst_ni pulse at vector 5 -> IDLE at once; restart -> signature_o identical to uninterrupted run.
REQ-034 SHALL verify start handling: start_i held high through RUN -> RUN length unchanged; start_i in DONE -> new run with MISR cleared.
